cpu_debug_ctrl: RTL and testbench
=================================

// Module: cpu_debug_ctrl
// PURPOSE
//  Synthesizable run/debug sequencer for the single-cycle MIPS computer; replaces the fixed-delay reset/run/reg_sel bench flow.
//  On start: holds the CPU in reset, runs it for a cycle budget or until a PC breakpoint, then scans the register file via reg_sel/reg_data.
//  Each scanned value is streamed out on a valid/ready port and folded into a signature for pass/fail checking.
// PARAMETERS
//  ADDR_W     32  PC / breakpoint address width
//  DATA_W     32  register data width
//  SEL_W       5  reg_sel width
//  NREG       32  registers scanned (indices 0..NREG-1), NREG <= 2**SEL_W
//  NBKPT       2  breakpoint channels
//  CYC_W      16  cycle counter / budget width
//  RST_CYCLES  2  cycles the CPU is held in reset per run (>=1)
// PORTS
//  clk         in   1              system clock
//  rst         in   1              asynchronous active-high reset
//  start       in   1              begin a run; sampled in IDLE or DONE, ignored otherwise
//  abort       in   1              terminate an active run
//  max_cycles  in   CYC_W          CPU cycle budget, latched on start
//  bkpt_en     in   NBKPT          per-channel breakpoint enable, latched on start
//  bkpt_addr   in   NBKPT*ADDR_W   breakpoint PCs, channel k = [k*ADDR_W +: ADDR_W], latched on start
//  pc          in   ADDR_W         current CPU PC
//  reg_data    in   DATA_W         CPU register read data for reg_sel (combinational in CPU)
//  cpu_rstn    out  1              CPU reset, active-low
//  cpu_clk_en  out  1              CPU clock enable (advances one instruction per enabled cycle)
//  reg_sel     out  SEL_W          CPU register select (registered)
//  dump_valid  out  1              dump beat valid
//  dump_ready  in   1              dump beat accepted
//  dump_idx    out  SEL_W          register index of the beat
//  dump_data   out  DATA_W         register value of the beat
//  busy        out  1              state not IDLE/DONE
//  done        out  1              state == DONE
//  halt_cause  out  2              00 none, 01 budget, 10 breakpoint, 11 abort
//  cycle_count out  CYC_W          enabled CPU cycles in the last/current run
//  signature   out  DATA_W         rotate-XOR signature of scanned registers
// BEHAVIOUR
//  Reset: state IDLE; cpu_rstn=0, cpu_clk_en=0, reg_sel=0, dump_valid=0, dump_idx=0, dump_data=0,
//   busy=0, done=0, halt_cause=00, cycle_count=0, signature=0.
//  FSM states and transitions:
//   IDLE/DONE --start--> RSTH: latch config; clear cycle_count, signature, halt_cause.
//   RSTH: cpu_rstn=0 for exactly RST_CYCLES cycles -> RUN.
//   RUN: cpu_rstn=1; hit = OR over k of (bkpt_en[k] && pc==bkpt_addr[k]); budget = (cycle_count==max_cycles).
//    cpu_clk_en = !hit && !budget && !abort (combinational); cycle_count += 1 per enabled cycle.
//    On hit -> SCAN_SEL, cause 10 (hit wins over budget in same cycle); else on budget -> SCAN_SEL, cause 01.
//    max_cycles==0 -> zero enabled cycles, cause 01. Breakpoint on reset PC -> zero cycles, cause 10.
//   SCAN_SEL: reg_sel <= idx -> SCAN_CAP.
//   SCAN_CAP: dump_data <= reg_data, dump_idx <= idx, dump_valid <= 1;
//    signature <= {signature[DATA_W-2:0], signature[DATA_W-1]} ^ reg_data -> SCAN_OUT.
//   SCAN_OUT: hold dump_* stable while !dump_ready. On dump_valid && dump_ready: dump_valid <= 0;
//    idx==NREG-1 -> DONE, else idx+1 -> SCAN_SEL. A register costs 3 cycles minimum.
//   DONE: cpu_rstn=1, cpu_clk_en=0 (CPU frozen, state inspectable); done=1 until next start.
//  cpu_rstn=0 in IDLE and RSTH only; cpu_clk_en=0 outside RUN.
//  abort: in RSTH/RUN/SCAN_* -> DONE next cycle, cause 11, dump_valid deasserted, scan abandoned; ignored in IDLE/DONE.
//  start while busy: ignored. start and abort same cycle in DONE: start wins.
//  cycle_count saturates at 2**CYC_W-1; budget compare is unaffected.
//  Async rst mid-run: immediate return to reset values; CPU re-held in reset.
// TESTING
//  1 start, max_cycles=10, no bkpt -> cpu_rstn low 2 cycles, 10 enabled cycles, cause 01, cycle_count=10, 32 beats idx 0..31.
//  2 bkpt_en=01, bkpt_addr0=0x00003008 (3rd instr) -> halts with pc=0x3008, cycle_count=2, cause 10; bkpt + budget same cycle -> cause 10.
//  3 dump_ready low 5 cycles on beat 7 -> dump_idx=7 and dump_data held stable; signature matches bench model.
//  4 max_cycles=0 -> cycle_count=0, cause 01, scan runs; abort mid-scan at idx 4 -> DONE, cause 11, no further beats.
//  5 rst asserted mid-RUN -> all outputs at reset values same edge; start in busy state ignored; second start from DONE reruns identically.

Source files
------------

// File: rtl/cpu_debug_ctrl.sv
// Run/debug sequencer: holds the CPU in reset, runs it under a cycle budget or breakpoints, then scans its register file.
// Latency: RST_CYCLES reset cycles, then the run, then at least 3 cycles per scanned register.
// Backpressure: a dump beat is held stable while dump_ready is low; the scan stalls until the beat is accepted.
module cpu_debug_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SEL_W      = 5,
    parameter int NREG       = 32,
    parameter int NBKPT      = 2,
    parameter int CYC_W      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CYC_W-1:0]        max_cycles,
    input  logic [NBKPT-1:0]        bkpt_en,
    input  logic [NBKPT*ADDR_W-1:0] bkpt_addr,
    input  logic [ADDR_W-1:0]       pc,
    input  logic [DATA_W-1:0]       reg_data,
    output logic                    cpu_rstn,
    output logic                    cpu_clk_en,
    output logic [SEL_W-1:0]        reg_sel,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [SEL_W-1:0]        dump_idx,
    output logic [DATA_W-1:0]       dump_data,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              halt_cause,
    output logic [CYC_W-1:0]        cycle_count,
    output logic [DATA_W-1:0]       signature
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BUDGET = 2'b01;
    localparam logic [1:0] CAUSE_BKPT   = 2'b10;
    localparam logic [1:0] CAUSE_ABORT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RSTH, S_RUN, S_SEL, S_CAP, S_OUT, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CYC_W-1:0]        max_q;
    logic [NBKPT-1:0]        bkpt_en_q;
    logic [NBKPT*ADDR_W-1:0] bkpt_addr_q;
    logic [RC_W-1:0]         rst_cnt;
    logic [SEL_W-1:0]        idx;

    logic hit;
    logic budget;
    logic rst_last;
    logic idx_last;
    logic beat_xfer;

    // Breakpoint match: any enabled channel whose address equals the live PC
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NBKPT; k++) begin
            if (bkpt_en_q[k] && (pc == bkpt_addr_q[k*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
            end
        end
    end

    assign budget    = (cycle_count == max_q);
    assign rst_last  = (rst_cnt == RC_W'(RST_CYCLES - 1));
    assign idx_last  = (idx == SEL_W'(NREG - 1));
    assign beat_xfer = dump_valid && dump_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort pre-empts everything in the active states
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RSTH;
            S_RSTH:  if (abort) state_nxt = S_DONE;
                     else if (rst_last) state_nxt = S_RUN;
            S_RUN:   if (abort) state_nxt = S_DONE;
                     else if (hit || budget) state_nxt = S_SEL;
            S_SEL:   state_nxt = abort ? S_DONE : S_CAP;
            S_CAP:   state_nxt = abort ? S_DONE : S_OUT;
            S_OUT:   if (abort) state_nxt = S_DONE;
                     else if (beat_xfer) state_nxt = idx_last ? S_DONE : S_SEL;
            S_DONE:  if (start) state_nxt = S_RSTH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; the CPU only advances in RUN when nothing is stopping it
    always_comb begin
        cpu_rstn   = !((state == S_IDLE) || (state == S_RSTH));
        cpu_clk_en = (state == S_RUN) && !hit && !budget && !abort;
        busy       = !((state == S_IDLE) || (state == S_DONE));
        done       = (state == S_DONE);
    end

    // Datapath: config latch, run counters, scan capture and signature folding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q       <= '0;
            bkpt_en_q   <= '0;
            bkpt_addr_q <= '0;
            rst_cnt     <= '0;
            idx         <= '0;
            reg_sel     <= '0;
            dump_valid  <= 1'b0;
            dump_idx    <= '0;
            dump_data   <= '0;
            halt_cause  <= CAUSE_NONE;
            cycle_count <= '0;
            signature   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        max_q       <= max_cycles;
                        bkpt_en_q   <= bkpt_en;
                        bkpt_addr_q <= bkpt_addr;
                        rst_cnt     <= '0;
                        idx         <= '0;
                        halt_cause  <= CAUSE_NONE;
                        cycle_count <= '0;
                        signature   <= '0;
                    end
                end
                S_RSTH: begin
                    if (abort) begin
                        halt_cause <= CAUSE_ABORT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        halt_cause <= CAUSE_ABORT;
                    end else if (hit) begin
                        halt_cause <= CAUSE_BKPT;
                    end else if (budget) begin
                        halt_cause <= CAUSE_BUDGET;
                    end else if (cycle_count != {CYC_W{1'b1}}) begin
                        // this is exactly the cycle the CPU clock is enabled
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                S_SEL: begin
                    if (abort) begin
                        halt_cause <= CAUSE_ABORT;
                    end else begin
                        reg_sel <= idx;
                    end
                end
                S_CAP: begin
                    if (abort) begin
                        halt_cause <= CAUSE_ABORT;
                    end else begin
                        dump_data  <= reg_data;
                        dump_idx   <= idx;
                        dump_valid <= 1'b1;
                        signature  <= {signature[DATA_W-2:0], signature[DATA_W-1]} ^ reg_data;
                    end
                end
                S_OUT: begin
                    if (abort) begin
                        halt_cause <= CAUSE_ABORT;
                        dump_valid <= 1'b0;
                    end else if (beat_xfer) begin
                        dump_valid <= 1'b0;
                        if (!idx_last) begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: a toy CPU (PC steps by 4 from 0x3000, random register file) driven by the sequencer.
// Each run is predicted from the halting rules (first breakpoint reached within budget, else budget) and the signature fold.
// Includes stalls on the dump port, abort mid-scan, async reset mid-run and start while busy.
module tb_cpu_debug_ctrl;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] max_cycles = '0;
    logic [1:0]  bkpt_en = '0;
    logic [63:0] bkpt_addr = '0;
    logic [31:0] pc;
    logic [31:0] reg_data;
    logic        dump_ready = 1'b1;
    logic        cpu_rstn, cpu_clk_en, dump_valid, busy, done;
    logic [4:0]  reg_sel, dump_idx;
    logic [31:0] dump_data, signature;
    logic [1:0]  halt_cause;
    logic [15:0] cycle_count;

    logic [31:0] regs [NREG];

    int errors = 0;
    int checks = 0;

    cpu_debug_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .max_cycles(max_cycles), .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
        .pc(pc), .reg_data(reg_data),
        .cpu_rstn(cpu_rstn), .cpu_clk_en(cpu_clk_en), .reg_sel(reg_sel),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data),
        .busy(busy), .done(done), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .signature(signature)
    );

    always #5 clk = ~clk;

    // toy CPU: reset PC 0x3000, one 4-byte instruction per enabled cycle
    always @(posedge clk or posedge rst) begin
        if (rst || !cpu_rstn) pc <= 32'h3000;
        else if (cpu_clk_en)  pc <= pc + 32'd4;
    end

    assign reg_data = regs[reg_sel];

    // observation of the run as seen at the CPU and the dump port
    int          en_cnt, rstl_cnt, stall_cyc, stall_bad, stall_idx;
    logic        stalled_prev;
    logic [4:0]  held_idx;
    logic [31:0] held_dat;
    logic [4:0]  beat_idx[$];
    logic [31:0] beat_dat[$];

    always @(posedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else if (start && !busy) begin
            en_cnt = 0; rstl_cnt = 0; stall_cyc = 0; stall_bad = 0; stall_idx = -1;
            stalled_prev = 1'b0;
            beat_idx.delete();
            beat_dat.delete();
        end else begin
            if (busy && !cpu_rstn) rstl_cnt++;
            if (cpu_clk_en) en_cnt++;
            if (dump_valid && dump_ready) begin
                beat_idx.push_back(dump_idx);
                beat_dat.push_back(dump_data);
            end
            if (stalled_prev && (!dump_valid || dump_idx !== held_idx || dump_data !== held_dat))
                stall_bad++;
            stalled_prev = dump_valid && !dump_ready;
            if (stalled_prev) begin
                stall_cyc++;
                stall_idx = int'(dump_idx);
            end
            held_idx = dump_idx;
            held_dat = dump_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_run(input string nm, input int mc, input logic [1:0] en,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input int stall_beat, input int abort_beat,
                          input int busy_start_at, input bit with_abort, input bit new_regs);
        int          n_hit, n, exp_cnt, exp_cause, nb, bad, stall_n;
        bit          finished, aborted;
        logic [31:0] addr, sig;
        if (new_regs) for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        @(negedge clk);
        max_cycles = 16'(mc); bkpt_en = en; bkpt_addr = {a1, a0};
        start = 1'b1; abort = with_abort;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        if (with_abort) begin
            chk({nm, "/start_wins_busy"}, 64'(busy), 64'd1);
            chk({nm, "/start_wins_cause"}, 64'(halt_cause), 64'd0);
        end
        finished = 0; aborted = 0; stall_n = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            if (done) begin
                finished = 1;
            end else begin
                start = (c == busy_start_at);
                dump_ready = !(dump_valid && int'(dump_idx) == stall_beat && stall_n < 5);
                if (!dump_ready) stall_n++;
                abort = (abort_beat >= 0 && !aborted && beat_idx.size() == abort_beat && busy && !dump_valid);
                if (abort) aborted = 1;
            end
        end
        start = 1'b0; abort = 1'b0; dump_ready = 1'b1;
        if (!finished) chk({nm, "/timeout"}, 64'd0, 64'd1);

        // expected halt: earliest enabled breakpoint reachable within the budget wins
        n_hit = -1;
        for (int k = 0; k < 2; k++) begin
            addr = (k == 0) ? a0 : a1;
            if (en[k] && addr >= 32'h3000 && addr[1:0] == 2'b00) begin
                n = int'((addr - 32'h3000) >> 2);
                if (n_hit < 0 || n < n_hit) n_hit = n;
            end
        end
        if (n_hit >= 0 && n_hit <= mc) begin exp_cnt = n_hit; exp_cause = 2; end
        else                           begin exp_cnt = mc;    exp_cause = 1; end
        nb = NREG;
        if (abort_beat >= 0) begin exp_cause = 3; nb = abort_beat; end

        sig = 32'd0;
        for (int i = 0; i < nb; i++) sig = ((sig << 1) | (sig >> 31)) ^ regs[i];
        bad = 0;
        for (int i = 0; i < beat_idx.size() && i < NREG; i++)
            if (beat_idx[i] !== 5'(i) || beat_dat[i] !== regs[i]) bad++;

        chk({nm, "/done"},        64'(done), 64'd1);
        chk({nm, "/busy"},        64'(busy), 64'd0);
        chk({nm, "/cause"},       64'(halt_cause), 64'(exp_cause));
        chk({nm, "/cycle_count"}, 64'(cycle_count), 64'(exp_cnt));
        chk({nm, "/en_cycles"},   64'(en_cnt), 64'(exp_cnt));
        chk({nm, "/pc"},          64'(pc), 64'(32'h3000 + 32'(exp_cnt) * 4));
        chk({nm, "/rst_cycles"},  64'(rstl_cnt), 64'd2);
        chk({nm, "/nbeats"},      64'(beat_idx.size()), 64'(nb));
        chk({nm, "/beat_bad"},    64'(bad), 64'd0);
        chk({nm, "/signature"},   64'(signature), 64'(sig));
        chk({nm, "/dump_valid"},  64'(dump_valid), 64'd0);
        if (stall_beat >= 0) begin
            chk({nm, "/stall_cycles"}, 64'(stall_cyc), 64'd5);
            chk({nm, "/stall_idx"},    64'(stall_idx), 64'(stall_beat));
            chk({nm, "/stall_stable"}, 64'(stall_bad), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) regs[i] = $urandom;
        repeat (3) @(negedge clk);
        chk("rst/cpu_rstn",    64'(cpu_rstn), 64'd0);
        chk("rst/cpu_clk_en",  64'(cpu_clk_en), 64'd0);
        chk("rst/reg_sel",     64'(reg_sel), 64'd0);
        chk("rst/dump_valid",  64'(dump_valid), 64'd0);
        chk("rst/dump_idx",    64'(dump_idx), 64'd0);
        chk("rst/dump_data",   64'(dump_data), 64'd0);
        chk("rst/busy",        64'(busy), 64'd0);
        chk("rst/done",        64'(done), 64'd0);
        chk("rst/halt_cause",  64'(halt_cause), 64'd0);
        chk("rst/cycle_count", 64'(cycle_count), 64'd0);
        chk("rst/signature",   64'(signature), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle/cpu_rstn",   64'(cpu_rstn), 64'd0);

        do_run("budget10",   10, 2'b00, 32'h0,    32'h0,    -1, -1, -1, 0, 1);
        do_run("bkpt3008",   50, 2'b01, 32'h3008, 32'h0,    -1, -1, -1, 0, 1);
        do_run("bkpt_tie",    2, 2'b01, 32'h3008, 32'h0,    -1, -1, -1, 0, 1);
        do_run("bkpt_ch1",   40, 2'b11, 32'h3100, 32'h3020, -1, -1, -1, 0, 1);
        do_run("bkpt_rstpc", 20, 2'b10, 32'h0,    32'h3000, -1, -1, -1, 0, 1);
        do_run("stall7", $urandom_range(5, 30), 2'b00, 32'h0, 32'h0, 7, -1, -1, 0, 1);
        do_run("zero_abort",  0, 2'b00, 32'h0,    32'h0,    -1, 4, -1, 0, 1);

        for (int r = 0; r < 4; r++) begin
            do_run("random", $urandom_range(0, 60), 2'($urandom_range(0, 3)),
                   32'h3000 + 32'($urandom_range(0, 70)) * 4,
                   32'h3000 + 32'($urandom_range(0, 70)) * 4,
                   -1, -1, -1, 1'($urandom_range(0, 1)), 1);
        end

        do_run("busy_start", 20, 2'b00, 32'h0, 32'h0, -1, -1, 6, 0, 1);
        do_run("rerun",      20, 2'b00, 32'h0, 32'h0, -1, -1, -1, 0, 0);

        // async reset in the middle of RUN
        @(negedge clk);
        max_cycles = 16'd200; bkpt_en = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst/running", 64'(cpu_clk_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst/cpu_rstn",    64'(cpu_rstn), 64'd0);
        chk("midrst/cpu_clk_en",  64'(cpu_clk_en), 64'd0);
        chk("midrst/busy",        64'(busy), 64'd0);
        chk("midrst/done",        64'(done), 64'd0);
        chk("midrst/halt_cause",  64'(halt_cause), 64'd0);
        chk("midrst/cycle_count", 64'(cycle_count), 64'd0);
        chk("midrst/signature",   64'(signature), 64'd0);
        chk("midrst/reg_sel",     64'(reg_sel), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_run("after_rst", 12, 2'b01, 32'h3010, 32'h0, -1, -1, -1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
